// File: rtl/dtree_feature_loader.sv
// Byte-serial feature loader for the printed decision tree: shadow bank, atomic commit, settle, class handshake.
// Optional statistics counters are built when DTREE_LOADER_STATS_EN is defined.
module dtree_feature_loader #(
  parameter int N_FEAT = 45,
  parameter int W      = 8,
  parameter int CLS_W  = 5,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [N_FEAT*W-1:0] feat_bus,
  input  logic [CLS_W-1:0]    tree_class,
  output logic [CLS_W-1:0]    m_class,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                err_len,
  output logic [15:0]         stat_samples,
  output logic [15:0]         stat_errors
);

  localparam int IDX_W = $clog2(N_FEAT);
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {LD_LOAD, LD_DRAIN, LD_FULL} ld_st_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SETTLE, OUT_HOLD} out_st_e;

  ld_st_e              ld_q, ld_d;
  out_st_e             out_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_FEAT*W-1:0] shadow_q;
  logic [N_FEAT*W-1:0] feat_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CLS_W-1:0]    m_class_q;
  logic                m_valid_q;
  logic                err_q;
  logic                s_ready_q;

  logic xfer, idx_last, commit, err_evt;

  assign xfer     = s_valid && s_ready_q;
  assign idx_last = (idx_q == IDX_W'(N_FEAT - 1));
  assign commit   = (ld_q == LD_FULL) && (out_q == OUT_IDLE);
  // A length error is s_last arriving anywhere but the final slot, or missing from it.
  assign err_evt  = xfer && (ld_q == LD_LOAD) && (s_last != idx_last);

  always_comb begin
    ld_d  = ld_q;
    idx_d = idx_q;
    case (ld_q)
      LD_LOAD: begin
        if (xfer) begin
          if (s_last || idx_last) idx_d = '0;
          else                    idx_d = idx_q + IDX_W'(1);
          if (s_last && idx_last)       ld_d = LD_FULL;
          else if (!s_last && idx_last) ld_d = LD_DRAIN;
        end
      end
      LD_DRAIN: if (xfer && s_last) ld_d = LD_LOAD;
      LD_FULL:  if (commit) ld_d = LD_LOAD;
      default:  ld_d = LD_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q      <= LD_LOAD;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ld_q      <= ld_d;
      idx_q     <= idx_d;
      s_ready_q <= (ld_d != LD_FULL);
      if (err_evt) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && (ld_q == LD_LOAD)) shadow_q[idx_q*W +: W] <= s_data;
  end

  // Output side: feat_bus only moves on commit, so the tree sees a stable vector through SETTLE and HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= OUT_IDLE;
      cnt_q     <= '0;
      m_class_q <= '0;
      m_valid_q <= 1'b0;
      feat_q    <= '0;
    end else begin
      case (out_q)
        OUT_IDLE: begin
          if (commit) begin
            feat_q <= shadow_q;
            cnt_q  <= CNT_W'(SETTLE - 1);
            out_q  <= OUT_SETTLE;
          end
        end
        OUT_SETTLE: begin
          if (cnt_q == '0) begin
            m_class_q <= tree_class;
            m_valid_q <= 1'b1;
            out_q     <= OUT_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        OUT_HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            out_q     <= OUT_IDLE;
          end
        end
        default: out_q <= OUT_IDLE;
      endcase
    end
  end

`ifdef DTREE_LOADER_STATS_EN
  logic [15:0] nsamp_q, nerr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nsamp_q <= '0;
      nerr_q  <= '0;
    end else begin
      if (commit && (nsamp_q != 16'hFFFF)) nsamp_q <= nsamp_q + 16'd1;
      if (err_evt && (nerr_q != 16'hFFFF)) nerr_q  <= nerr_q + 16'd1;
    end
  end

  assign stat_samples = nsamp_q;
  assign stat_errors  = nerr_q;
`else
  assign stat_samples = 16'd0;
  assign stat_errors  = 16'd0;
`endif

  assign s_ready  = s_ready_q;
  assign feat_bus = feat_q;
  assign m_class  = m_class_q;
  assign m_valid  = m_valid_q;
  assign err_len  = err_q;

endmodule
